// File: rtl/mtimer.sv
`default_nettype none
// ============================================================================
// mtimer : 64-bit machine timer with prescaler, mtimecmp level interrupt and
//          req/gnt/rvalid register slave.            Rev 1.0
// ============================================================================
module mtimer #(
   parameter int PRESC_W = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [3:0]  be,
   input  logic [4:0]  addr,
   input  logic [31:0] wdata,
   output logic        gnt,
   output logic        rvalid,
   output logic [31:0] rdata,
   output logic        timer_irq
);

   localparam logic [2:0] C_MTIME_LO = 3'd0;
   localparam logic [2:0] C_MTIME_HI = 3'd1;
   localparam logic [2:0] C_CMP_LO   = 3'd2;
   localparam logic [2:0] C_CMP_HI   = 3'd3;
   localparam logic [2:0] C_CTRL     = 3'd4;

   function automatic logic [31:0] merge(input logic [31:0] old_v,
                                         input logic [31:0] new_v,
                                         input logic [3:0]  en);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++)
         if (en[i]) r[8*i +: 8] = new_v[8*i +: 8];
      return r;
   endfunction

   logic [63:0]        mtime_q, mtime_d;
   logic [31:0]        shadow_q;
   logic [63:0]        mtimecmp_q;
   logic               en_q;
   logic [PRESC_W-1:0] presc_q;
   logic [PRESC_W-1:0] cnt_q, cnt_d;
   logic               rvalid_q;
   logic [31:0]        rdata_q;
   logic               irq_q;

   logic [2:0]  w_word;
   logic        w_rd, w_wr, w_tick;
   logic        w_wr_mlo, w_wr_mhi, w_wr_clo, w_wr_chi, w_wr_ctrl;
   logic [31:0] w_ctrl, w_ctrl_new, w_rmux;
   logic        w_unused;

   assign w_word    = addr[4:2];
   assign w_rd      = req & ~we;
   // A write with no byte enables must not suppress a tick or clear the prescaler.
   assign w_wr      = req & we & (|be);
   assign w_wr_mlo  = w_wr && (w_word == C_MTIME_LO);
   assign w_wr_mhi  = w_wr && (w_word == C_MTIME_HI);
   assign w_wr_clo  = w_wr && (w_word == C_CMP_LO);
   assign w_wr_chi  = w_wr && (w_word == C_CMP_HI);
   assign w_wr_ctrl = w_wr && (w_word == C_CTRL);
   assign w_tick    = en_q && (cnt_q == presc_q);

   always_comb begin
      w_ctrl              = '0;
      w_ctrl[0]           = en_q;
      w_ctrl[8 +: PRESC_W] = presc_q;
   end

   assign w_ctrl_new = merge(w_ctrl, wdata, be);
   assign w_unused   = ^{addr[1:0], w_ctrl_new};

   always_comb begin
      mtime_d = mtime_q;
      if (w_wr_mlo)
         mtime_d[31:0] = merge(mtime_q[31:0], wdata, be);
      else if (w_wr_mhi)
         mtime_d[63:32] = merge(mtime_q[63:32], wdata, be);
      else if (w_tick)
         mtime_d = mtime_q + 64'd1;

      cnt_d = cnt_q;
      if (w_wr_ctrl || w_tick)
         cnt_d = '0;
      else if (en_q)
         cnt_d = cnt_q + PRESC_W'(1);
   end

   always_comb begin
      w_rmux = '0;
      case (w_word)
         C_MTIME_LO: w_rmux = mtime_q[31:0];
         C_MTIME_HI: w_rmux = shadow_q;
         C_CMP_LO:   w_rmux = mtimecmp_q[31:0];
         C_CMP_HI:   w_rmux = mtimecmp_q[63:32];
         C_CTRL:     w_rmux = w_ctrl;
         default:    w_rmux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtime_q    <= '0;
         shadow_q   <= '0;
         mtimecmp_q <= '1;
         en_q       <= 1'b1;
         presc_q    <= '0;
         cnt_q      <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         irq_q      <= 1'b0;
      end else begin
         mtime_q <= mtime_d;
         cnt_q   <= cnt_d;
         // Latch the upper half with the low-word read so LO-then-HI is coherent.
         if (w_rd && (w_word == C_MTIME_LO))
            shadow_q <= mtime_q[63:32];
         if (w_wr_clo)
            mtimecmp_q[31:0] <= merge(mtimecmp_q[31:0], wdata, be);
         if (w_wr_chi)
            mtimecmp_q[63:32] <= merge(mtimecmp_q[63:32], wdata, be);
         if (w_wr_ctrl) begin
            en_q    <= w_ctrl_new[0];
            presc_q <= w_ctrl_new[8 +: PRESC_W];
         end
         rvalid_q <= req;
         rdata_q  <= w_rd ? w_rmux : 32'd0;
         irq_q    <= (mtime_q >= mtimecmp_q);
      end
   end

   assign gnt       = req;
   assign rvalid    = rvalid_q;
   assign rdata     = rdata_q;
   assign timer_irq = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_mtimer.sv
`default_nettype none
// ============================================================================
// tb_mtimer : directed self-checking bench for mtimer.     Rev 1.0
// ============================================================================
module tb_mtimer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  be = 4'd0;
   logic [4:0]  addr = 5'd0;
   logic [31:0] wdata = 32'd0;
   logic        gnt, rvalid, timer_irq;
   logic [31:0] rdata;

   int n_cmp = 0;
   int n_err = 0;

   mtimer #(.PRESC_W(16)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr),
      .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .timer_irq(timer_irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Called just after a falling edge; the access is granted on the next rising edge.
   task automatic xfer(input logic w, input logic [4:0] a, input logic [3:0] b,
                       input logic [31:0] d, output logic [31:0] rd);
      req = 1'b1; we = w; addr = a; be = b; wdata = d;
      #1 chk("gnt", {63'd0, gnt}, 64'd1);
      @(negedge clk);
      chk("rvalid", {63'd0, rvalid}, 64'd1);
      rd  = rdata;
      req = 1'b0; we = 1'b0; be = 4'd0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [3:0] b, input logic [31:0] d);
      logic [31:0] dummy;
      xfer(1'b1, a, b, d, dummy);
   endtask

   task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
      logic [31:0] v;
      xfer(1'b0, a, 4'd0, 32'd0, v);
      chk(tag, {32'd0, v}, {32'd0, exp});
   endtask

   logic [31:0] m0, m1;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
      chk("rst_rdata", {32'd0, rdata}, 64'd0);
      chk("rst_irq", {63'd0, timer_irq}, 64'd0);
      chk("rst_gnt", {63'd0, gnt}, 64'd0);
      rst = 1'b0;

      // free-running with PRESC = 0
      repeat (10) @(negedge clk);
      rd_chk("idle_lo", 5'h00, 32'd10);
      rd_chk("idle_hi", 5'h04, 32'd0);
      chk("idle_irq", {63'd0, timer_irq}, 64'd0);

      // prescaler 4 then disable
      wr(5'h10, 4'hF, 32'h0000_0401);
      xfer(1'b0, 5'h00, 4'd0, 32'd0, m0);
      repeat (49) @(negedge clk);
      rd_chk("presc_adv", 5'h00, m0 + 32'd10);
      rd_chk("ctrl_rd", 5'h10, 32'h0000_0401);
      wr(5'h10, 4'hF, 32'h0);
      xfer(1'b0, 5'h00, 4'd0, 32'd0, m1);
      repeat (19) @(negedge clk);
      rd_chk("frozen", 5'h00, m1);
      rd_chk("ctrl_off", 5'h10, 32'h0);

      // carry and snapshot
      wr(5'h00, 4'hF, 32'hFFFF_FFFE);
      wr(5'h04, 4'hF, 32'h0);
      wr(5'h10, 4'hF, 32'h1);
      @(negedge clk);
      rd_chk("snap_lo", 5'h00, 32'hFFFF_FFFF);
      rd_chk("snap_hi", 5'h04, 32'h0);
      rd_chk("carry_lo", 5'h00, 32'h1);
      rd_chk("carry_hi", 5'h04, 32'h1);

      // compare interrupt rise and fall
      wr(5'h10, 4'hF, 32'h0);
      wr(5'h00, 4'hF, 32'h0);
      wr(5'h04, 4'hF, 32'h0);
      wr(5'h0C, 4'hF, 32'h0);
      wr(5'h08, 4'hF, 32'd100);
      chk("irq_idle", {63'd0, timer_irq}, 64'd0);
      wr(5'h10, 4'hF, 32'h1);
      repeat (100) @(negedge clk);
      chk("irq_at100", {63'd0, timer_irq}, 64'd0);
      @(negedge clk);
      chk("irq_rise", {63'd0, timer_irq}, 64'd1);
      wr(5'h08, 4'hF, 32'hFFFF_FFFF);
      chk("irq_hold", {63'd0, timer_irq}, 64'd1);
      @(negedge clk);
      chk("irq_fall", {63'd0, timer_irq}, 64'd0);

      // byte-merge write on a tick cycle
      wr(5'h10, 4'hF, 32'h0);
      wr(5'h00, 4'hF, 32'h1234_5678);
      wr(5'h04, 4'hF, 32'h0);
      wr(5'h10, 4'hF, 32'h1);
      wr(5'h00, 4'b0010, 32'h0000_AB00);
      rd_chk("merge_lo", 5'h00, 32'h1234_AB78);
      rd_chk("unmapped18", 5'h18, 32'h0);
      wr(5'h10, 4'b0000, 32'h0000_0000);
      rd_chk("be0_ctrl", 5'h10, 32'h1);

      // force irq then reset during an outstanding read
      wr(5'h0C, 4'hF, 32'h0);
      wr(5'h08, 4'hF, 32'h0);
      @(negedge clk);
      chk("irq_forced", {63'd0, timer_irq}, 64'd1);
      req = 1'b1; we = 1'b0; addr = 5'h00; be = 4'd0;
      @(posedge clk);
      #1 chk("rvalid_pre", {63'd0, rvalid}, 64'd1);
      rst = 1'b1; req = 1'b0;
      #1;
      chk("arst_rvalid", {63'd0, rvalid}, 64'd0);
      chk("arst_rdata", {32'd0, rdata}, 64'd0);
      chk("arst_irq", {63'd0, timer_irq}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      rd_chk("arst_mtime", 5'h00, 32'h0);
      rd_chk("arst_cmp_lo", 5'h08, 32'hFFFF_FFFF);
      rd_chk("arst_cmp_hi", 5'h0C, 32'hFFFF_FFFF);
      rd_chk("arst_ctrl", 5'h10, 32'h1);
      chk("arst_irq2", {63'd0, timer_irq}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
